// File: rtl/cmd_host_pkg.sv
// Shared opcodes, handshake bytes, state/status encodings and response classification
// for the command host and its configuration users.
package cmd_host_pkg;

  localparam logic [1:0] RD  = 2'b00;
  localparam logic [1:0] WR  = 2'b01;
  localparam logic [1:0] DMP = 2'b10;

  localparam logic [7:0] ACK      = 8'hA5;
  localparam logic [7:0] NAK_BYTE = 8'hEE;

  typedef enum logic [1:0] {
    ST_OK      = 2'd0,
    ST_NAK     = 2'd1,
    ST_TIMEOUT = 2'd2,
    ST_BADRESP = 2'd3
  } status_t;

  typedef enum logic [2:0] {
    IDLE, TX_HI, WAIT_HI, TX_LO, WAIT_LO, RX_WAIT, DONE
  } state_t;

  // Outcome of a terminating response byte; a dump only ends on its final byte, so it is always OK.
  function automatic status_t resp_status(input logic [1:0] op, input logic [7:0] b);
    status_t s;
    s = ST_OK;
    case (op)
      RD, DMP: s = ST_OK;
      WR:      s = (b == ACK) ? ST_OK : ((b == NAK_BYTE) ? ST_NAK : ST_BADRESP);
      default: s = (b == NAK_BYTE) ? ST_NAK : ST_BADRESP;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/cmd_host_tmr.sv
// Inter-byte response timeout: counts while enabled, holds at TIMEOUT_CYC-1 and flags expiry there.
module cmd_host_tmr #(
  parameter int TIMEOUT_CYC = 2**20
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] TERM = TW'(TIMEOUT_CYC - 1);

  logic [TW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (en_i && (cnt_q != TERM))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign expired_o = (cnt_q == TERM);

endmodule

// File: rtl/cmd_host.sv
// Command initiator: sends a 16-bit command as two UART bytes and classifies the reply.
// Define CMD_HOST_CHKSUM_EN to add the chksum output (XOR of all accepted response bytes).
module cmd_host #(
  parameter int ENTRIES     = 384,
  parameter int LOG2        = 9,
  parameter int TIMEOUT_CYC = 2**20
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [15:0]     cmd_in,
  input  logic            send_cmd,
  output logic            cmd_busy,
  output logic [7:0]      tx_data,
  output logic            trmt,
  input  logic            tx_done,
  input  logic [7:0]      rx_data,
  input  logic            rx_rdy,
  output logic            clr_rx_rdy,
  output logic [7:0]      resp_byte,
  output logic            resp_vld,
  output logic [LOG2:0]   byte_cnt,
  output logic            cmd_cmplt,
`ifdef CMD_HOST_CHKSUM_EN
  output logic [7:0]      chksum,
`endif
  output logic [1:0]      status
);
  import cmd_host_pkg::*;

  localparam logic [LOG2:0] ENT = (LOG2+1)'(ENTRIES);

  state_t        state_q;
  status_t       status_q;
  logic [1:0]    op_q;
  logic [7:0]    lo_q;
  logic [7:0]    tx_data_q, resp_byte_q;
  logic          trmt_q, clr_q, resp_vld_q, cmplt_q, busy_q;
  logic [LOG2:0] byte_cnt_q, byte_cnt_inc;
  logic          rx_take, tmr_expired;

  // rx_rdy is a level that stays high for the cycle our registered ack is in flight.
  assign rx_take      = rx_rdy && !clr_q;
  assign byte_cnt_inc = (byte_cnt_q == ENT) ? byte_cnt_q : byte_cnt_q + 1'b1;

  cmd_host_tmr #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_tmr (
    .clk       (clk),
    .rst       (rst),
    .clr_i     ((state_q != RX_WAIT) || rx_take),
    .en_i      (state_q == RX_WAIT),
    .expired_o (tmr_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      status_q    <= ST_OK;
      op_q        <= '0;
      lo_q        <= '0;
      tx_data_q   <= '0;
      resp_byte_q <= '0;
      trmt_q      <= 1'b0;
      clr_q       <= 1'b0;
      resp_vld_q  <= 1'b0;
      cmplt_q     <= 1'b0;
      busy_q      <= 1'b0;
      byte_cnt_q  <= '0;
    end else begin
      trmt_q     <= 1'b0;
      clr_q      <= 1'b0;
      resp_vld_q <= 1'b0;
      cmplt_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (rx_take) clr_q <= 1'b1;
          if (send_cmd) begin
            op_q       <= cmd_in[15:14];
            lo_q       <= cmd_in[7:0];
            tx_data_q  <= cmd_in[15:8];
            trmt_q     <= 1'b1;
            byte_cnt_q <= '0;
            status_q   <= ST_OK;
            busy_q     <= 1'b1;
            state_q    <= TX_HI;
          end
        end
        TX_HI: state_q <= WAIT_HI;
        WAIT_HI: begin
          if (tx_done) begin
            tx_data_q <= lo_q;
            trmt_q    <= 1'b1;
            state_q   <= TX_LO;
          end
        end
        TX_LO: state_q <= WAIT_LO;
        WAIT_LO: begin
          if (tx_done) state_q <= RX_WAIT;
        end
        RX_WAIT: begin
          if (rx_take) begin
            resp_byte_q <= rx_data;
            resp_vld_q  <= 1'b1;
            clr_q       <= 1'b1;
            byte_cnt_q  <= byte_cnt_inc;
            // A dump only terminates on its last byte, so an early 0xEE is plain data.
            if ((op_q != DMP) || (byte_cnt_inc == ENT)) begin
              status_q <= resp_status(op_q, rx_data);
              cmplt_q  <= 1'b1;
              state_q  <= DONE;
            end
          end else if (tmr_expired) begin
            status_q <= ST_TIMEOUT;
            cmplt_q  <= 1'b1;
            state_q  <= DONE;
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

`ifdef CMD_HOST_CHKSUM_EN
  logic [7:0] chksum_q;

  always_ff @(posedge clk) begin
    if (rst)
      chksum_q <= '0;
    else if ((state_q == IDLE) && send_cmd)
      chksum_q <= '0;
    else if ((state_q == RX_WAIT) && rx_take)
      chksum_q <= chksum_q ^ rx_data;
  end

  assign chksum = chksum_q;
`else
  // Default build carries no checksum state.
`endif

  assign cmd_busy   = busy_q;
  assign tx_data    = tx_data_q;
  assign trmt       = trmt_q;
  assign clr_rx_rdy = clr_q;
  assign resp_byte  = resp_byte_q;
  assign resp_vld   = resp_vld_q;
  assign byte_cnt   = byte_cnt_q;
  assign cmd_cmplt  = cmplt_q;
  assign status     = status_q;

endmodule
